// File: rtl/barrett_reduce_pipe.sv
// Pipelined Barrett reducer: out_data = in_data mod Q, with valid/ready handshake and a sideband tag.
// Optional range flag (out_err) is enabled by defining BARRETT_RANGE_CHECK_EN.
module barrett_reduce_pipe #(
   parameter int Q     = 2089,
   parameter int QW    = 12,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*QW-1:0]  in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW-1:0]    out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef BARRETT_RANGE_CHECK_EN
   ,
   output logic             out_err
`endif
);

   localparam int DW = 2 * QW;
   localparam logic [DW-1:0]   M    = DW'((64'd1 << DW) / Q);
   localparam logic [DW-1:0]   Q_DW = DW'(Q);
   localparam logic [QW+1:0]   Q_R  = (QW + 2)'(Q);
   localparam logic [QW+1:0]   Q2_R = (QW + 2)'(2 * Q);
   localparam logic [DW-1:0]   QSQ  = DW'(longint'(Q) * longint'(Q));

   logic             adv;
   logic             v0_q, v1_q, v2_q, out_valid_q;
   logic [DW-1:0]    x0_q, x1_q;
   logic [2*DW-1:0]  p1_q, p1_d;
   logic [QW+1:0]    r2_q, r2_d, r3_full;
   logic [QW-1:0]    out_data_q;
   logic [TAG_W-1:0] tag0_q, tag1_q, tag2_q, out_tag_q;
   logic [DW-1:0]    qe, qeq, diff;
   logic             unused_bits;
`ifdef BARRETT_RANGE_CHECK_EN
   logic             err0_q, err1_q, err2_q, out_err_q;
`endif

   // One enable for the whole pipe: a stalled output freezes every stage.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   assign p1_d = {{DW{1'b0}}, x0_q} * {{DW{1'b0}}, M};

   // Quotient estimate is at most 2 low, so the true remainder is < 3Q and fits QW+2 bits;
   // the subtraction can therefore be done modulo 2^DW and truncated.
   assign qe   = p1_q[2*DW-1:DW];
   assign qeq  = qe * Q_DW;
   assign diff = x1_q - qeq;
   assign r2_d = diff[QW+1:0];

   always_comb begin
      r3_full = r2_q;
      if (r2_q >= Q2_R)
         r3_full = r2_q - Q2_R;
      else if (r2_q >= Q_R)
         r3_full = r2_q - Q_R;
   end

   assign unused_bits = ^{p1_q[DW-1:0], diff[DW-1:QW+2], r3_full[QW+1:QW]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         x0_q        <= '0;
         x1_q        <= '0;
         p1_q        <= '0;
         r2_q        <= '0;
         out_data_q  <= '0;
         tag0_q      <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
         out_tag_q   <= '0;
`ifdef BARRETT_RANGE_CHECK_EN
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         err2_q      <= 1'b0;
         out_err_q   <= 1'b0;
`endif
      end else if (adv) begin
         v0_q        <= in_valid;
         v1_q        <= v0_q;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         // The input word is registered ahead of the multiplier so it sees a registered operand.
         if (in_valid) begin
            x0_q   <= in_data;
            tag0_q <= in_tag;
`ifdef BARRETT_RANGE_CHECK_EN
            err0_q <= (in_data >= QSQ);
`endif
         end
         if (v0_q) begin
            x1_q   <= x0_q;
            p1_q   <= p1_d;
            tag1_q <= tag0_q;
`ifdef BARRETT_RANGE_CHECK_EN
            err1_q <= err0_q;
`endif
         end
         if (v1_q) begin
            r2_q   <= r2_d;
            tag2_q <= tag1_q;
`ifdef BARRETT_RANGE_CHECK_EN
            err2_q <= err1_q;
`endif
         end
         if (v2_q) begin
            out_data_q <= r3_full[QW-1:0];
            out_tag_q  <= tag2_q;
`ifdef BARRETT_RANGE_CHECK_EN
            out_err_q  <= err2_q;
`endif
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
`ifdef BARRETT_RANGE_CHECK_EN
   assign out_err   = out_err_q;
`endif

endmodule
